// File: rtl/icache_data_array_pkg.sv
// Shared types and sizing for the instruction-cache data store.
// Geometry, address/word types and the refill FSM encoding.
package icache_pkg;

  localparam int LNUM  = 64;
  localparam int WNUM  = 16;
  localparam int WDSZ  = 32;
  localparam int RBKSZ = 4;
  localparam int BEATW = 4;

  localparam int LAW   = $clog2(LNUM);
  localparam int WAW   = $clog2(WNUM);
  localparam int BEATS = WNUM / BEATW;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [LAW-1:0]  laddr_t;
  typedef logic [WAW-1:0]  waddr_t;
  typedef logic [WDSZ-1:0] word_t;
  typedef logic [BCW-1:0]  beat_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  // A read spills into the next line when its block runs past the line end
  function automatic logic is_wrap(waddr_t w);
    return ({1'b0, w} + (WAW+1)'(RBKSZ)) > (WAW+1)'(WNUM);
  endfunction

endpackage

// File: rtl/icache_data_array_if.sv
// Read and refill bundle between fetch/refill logic and the data store.
// The store itself sits on the slave side.
interface icache_data_array_if
  import icache_pkg::*;
();

  logic                  rd_valid;
  logic                  rd_ready;
  laddr_t                rd_laddr;
  waddr_t                rd_waddr;
  logic                  dout_valid;
  logic [RBKSZ*WDSZ-1:0] dout;

  logic                  fill_start;
  laddr_t                fill_laddr;
  logic                  fill_valid;
  logic                  fill_ready;
  logic [BEATW*WDSZ-1:0] fill_data;
  logic                  fill_done;

  modport master (
    output rd_valid, rd_laddr, rd_waddr,
    output fill_start, fill_laddr, fill_valid, fill_data,
    input  rd_ready, dout_valid, dout,
    input  fill_ready, fill_done
  );

  modport slave (
    input  rd_valid, rd_laddr, rd_waddr,
    input  fill_start, fill_laddr, fill_valid, fill_data,
    output rd_ready, dout_valid, dout,
    output fill_ready, fill_done
  );

endinterface

// File: rtl/cache_bank_sdp.sv
// One word column: simple dual-port RAM, read-first, registered read.
// Output register is resettable so the assembled block reads 0 after reset.
module cache_bank_sdp
  import icache_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   we_i,
  input  laddr_t waddr_i,
  input  word_t  wdata_i,
  input  logic   re_i,
  input  laddr_t raddr_i,
  output word_t  rdata_o
);

  word_t mem [LNUM];
  word_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_data_array.sv
// Instruction-cache data store: rotated multi-word reads with line wrap
// and a beat-wise refill engine that blocks reads to the line in flight.
module icache_data_array
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  icache_data_array_if.slave   bus
);

  fill_state_t state_q;
  laddr_t      fill_line_q;
  beat_t       beat_q;
  waddr_t      waddr_q;
  logic        dout_valid_q;

  logic        wrap;
  laddr_t      nxt_line;
  logic        hit;
  logic        accept;

  laddr_t      raddr [WNUM];
  logic        we    [WNUM];
  word_t       col   [WNUM];
  logic [RBKSZ*WDSZ-1:0] rot;

  assign wrap     = is_wrap(bus.rd_waddr);
  assign nxt_line = bus.rd_laddr + LAW'(1);
  assign hit      = (bus.rd_laddr == fill_line_q) ||
                    (wrap && (nxt_line == fill_line_q));

  assign bus.rd_ready = !((state_q != IDLE) && hit);
  assign accept       = bus.rd_valid && bus.rd_ready;

  for (genvar c = 0; c < WNUM; c++) begin : g_col
    // Columns before the start offset belong to the following line
    assign raddr[c] = (wrap && (WAW'(c) < bus.rd_waddr))
                      ? nxt_line : bus.rd_laddr;
    assign we[c]    = (state_q == FILL) && bus.fill_valid &&
                      (beat_q == BCW'(c / BEATW));

    cache_bank_sdp u_bank (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (we[c]),
      .waddr_i (fill_line_q),
      .wdata_i (bus.fill_data[(c % BEATW)*WDSZ +: WDSZ]),
      .re_i    (accept),
      .raddr_i (raddr[c]),
      .rdata_o (col[c])
    );
  end

  always_comb begin
    rot = '0;
    for (int k = 0; k < RBKSZ; k++) begin
      rot[k*WDSZ +: WDSZ] = col[waddr_t'(waddr_q + WAW'(k))];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q      <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= accept;
      if (accept) waddr_q <= bus.rd_waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_line_q <= '0;
      beat_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.fill_start) begin
            fill_line_q <= bus.fill_laddr;
            beat_q      <= '0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (bus.fill_valid) begin
            beat_q <= beat_q + BCW'(1);
            if (beat_q == BCW'(BEATS-1)) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dout       = rot;
  assign bus.dout_valid = dout_valid_q;
  assign bus.fill_ready = (state_q == FILL);
  assign bus.fill_done  = (state_q == DONE);

endmodule

// File: tb/tb_icache_data_array.sv
// Directed bench for the icache data store with a per-cycle
// expected-output queue and a reference memory model.
module tb_icache_data_array;
  import icache_pkg::*;

  typedef logic [RBKSZ*WDSZ-1:0] blk_t;
  typedef struct {
    logic v;
    blk_t d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_data_array_if bus ();

  icache_data_array dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  sbq [$];
  word_t mem_m [LNUM][WNUM];
  int    total = 0;
  int    bad   = 0;
  blk_t  last_dout;
  logic  cur_acc;
  blk_t  cur_d;

  task automatic chk(string tag, blk_t obs, blk_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic blk_t model_rd(laddr_t l, waddr_t w);
    blk_t r;
    int   pos;
    r = '0;
    for (int k = 0; k < RBKSZ; k++) begin
      pos = (int'(l) * WNUM + int'(w) + k) % (LNUM * WNUM);
      r[k*WDSZ +: WDSZ] = mem_m[pos / WNUM][pos % WNUM];
    end
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    e.v = cur_acc;
    e.d = cur_d;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty obs=0 exp=1");
    end else begin
      e = sbq.pop_front();
      if (rst)      last_dout = '0;
      else if (e.v) last_dout = e.d;
      chk("dout_valid", blk_t'(bus.dout_valid), blk_t'(e.v && !rst));
      chk("dout", bus.dout, last_dout);
    end
    cur_acc      = 1'b0;
    bus.rd_valid = 1'b0;
  endtask

  task automatic rd(laddr_t l, waddr_t w, logic exp_rdy);
    bus.rd_valid = 1'b1;
    bus.rd_laddr = l;
    bus.rd_waddr = w;
    #1;
    chk("rd_ready", blk_t'(bus.rd_ready), blk_t'(exp_rdy));
    cur_acc = exp_rdy;
    if (exp_rdy) cur_d = model_rd(l, w);
  endtask

  task automatic beat(int b, laddr_t line, word_t base);
    bus.fill_valid = 1'b1;
    for (int j = 0; j < BEATW; j++) begin
      bus.fill_data[j*WDSZ +: WDSZ] = base + word_t'(b*BEATW + j);
      mem_m[line][b*BEATW + j] = base + word_t'(b*BEATW + j);
    end
    chk("fill_ready_beat", blk_t'(bus.fill_ready), blk_t'(1'b1));
    chk("fill_done_beat", blk_t'(bus.fill_done), blk_t'(1'b0));
  endtask

  task automatic fill(laddr_t line, word_t base);
    bus.fill_start = 1'b1;
    bus.fill_laddr = line;
    chk("fill_ready_idle", blk_t'(bus.fill_ready), blk_t'(1'b0));
    tick();
    bus.fill_start = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      beat(b, line, base);
      tick();
    end
    bus.fill_valid = 1'b0;
    chk("fill_done_pulse", blk_t'(bus.fill_done), blk_t'(1'b1));
    chk("fill_ready_done", blk_t'(bus.fill_ready), blk_t'(1'b0));
    tick();
    chk("fill_done_end", blk_t'(bus.fill_done), blk_t'(1'b0));
  endtask

  initial begin
    rst            = 1'b1;
    cur_acc        = 1'b0;
    cur_d          = '0;
    last_dout      = '0;
    bus.rd_valid   = 1'b0;
    bus.rd_laddr   = '0;
    bus.rd_waddr   = '0;
    bus.fill_start = 1'b0;
    bus.fill_laddr = '0;
    bus.fill_valid = 1'b0;
    bus.fill_data  = '0;

    tick();
    tick();
    chk("rst_rd_ready", blk_t'(bus.rd_ready), blk_t'(1'b1));
    chk("rst_fill_ready", blk_t'(bus.fill_ready), blk_t'(1'b0));
    chk("rst_fill_done", blk_t'(bus.fill_done), blk_t'(1'b0));
    rst = 1'b0;
    tick();

    fill(6'd5, 32'h500);
    rd(6'd5, 4'd2, 1'b1);
    chk("exp_5_2", cur_d, {32'h505, 32'h504, 32'h503, 32'h502});
    tick();

    fill(6'd6, 32'h600);
    rd(6'd5, 4'd14, 1'b1);
    chk("exp_5_14", cur_d, {32'h601, 32'h600, 32'h50F, 32'h50E});
    tick();

    fill(6'd63, 32'h3F00);
    fill(6'd0, 32'h0);
    rd(6'd63, 4'd13, 1'b1);
    chk("exp_63_13", cur_d, {32'h0, 32'h3F0F, 32'h3F0E, 32'h3F0D});
    tick();

    fill(6'd3, 32'h300);

    bus.fill_start = 1'b1;
    bus.fill_laddr = 6'd7;
    tick();
    bus.fill_start = 1'b0;
    beat(0, 6'd7, 32'h700);
    rd(6'd7, 4'd0, 1'b0);
    tick();
    beat(1, 6'd7, 32'h700);
    rd(6'd6, 4'd13, 1'b0);
    tick();
    beat(2, 6'd7, 32'h700);
    rd(6'd3, 4'd0, 1'b1);
    tick();
    beat(3, 6'd7, 32'h700);
    rd(6'd6, 4'd12, 1'b1);
    tick();
    bus.fill_valid = 1'b0;
    chk("hz_fill_done", blk_t'(bus.fill_done), blk_t'(1'b1));
    rd(6'd7, 4'd0, 1'b0);
    tick();
    chk("hz_idle_done", blk_t'(bus.fill_done), blk_t'(1'b0));
    rd(6'd7, 4'd0, 1'b1);
    tick();
    rd(6'd6, 4'd13, 1'b1);
    tick();

    bus.fill_start = 1'b1;
    bus.fill_laddr = 6'd9;
    tick();
    bus.fill_start = 1'b0;
    beat(0, 6'd9, 32'h900);
    tick();
    beat(1, 6'd9, 32'h900);
    tick();
    bus.fill_valid = 1'b0;
    rd(6'd5, 4'd0, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_fill_ready", blk_t'(bus.fill_ready), blk_t'(1'b0));
    chk("mid_rst_fill_done", blk_t'(bus.fill_done), blk_t'(1'b0));
    rst = 1'b0;
    tick();
    chk("post_rst_fill_done", blk_t'(bus.fill_done), blk_t'(1'b0));
    fill(6'd9, 32'h900);
    rd(6'd9, 4'd1, 1'b1);
    tick();

    bus.fill_valid = 1'b1;
    bus.fill_laddr = 6'd5;
    bus.fill_data  = {BEATW{32'hDEADBEEF}};
    tick();
    bus.fill_valid = 1'b0;
    chk("idle_fv_ready", blk_t'(bus.fill_ready), blk_t'(1'b0));
    rd(6'd5, 4'd0, 1'b1);
    tick();

    rd(6'd5, 4'd0, 1'b1);
    tick();
    rd(6'd6, 4'd15, 1'b1);
    tick();
    rd(6'd63, 4'd15, 1'b1);
    tick();
    rd(6'd0, 4'd3, 1'b1);
    tick();
    rd(6'd7, 4'd10, 1'b1);
    tick();
    rd(6'd3, 4'd12, 1'b1);
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
